// File: rtl/pipeline_run_ctrl.sv
// Run/step sequencer for the 5-stage core: turns start/step/stop commands into run and fetch enables.
// Optional watchdog enabled by defining PIPELINE_RUN_CTRL_CYCLE_LIMIT_EN.
module pipeline_run_ctrl #(
  parameter int STAGES     = 5,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_req,
  input  logic             stop_req,
  input  logic             halt_wb,
  output logic             run,
  output logic             fetch_en,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             done,
  output logic             limit_hit
);

`ifdef PIPELINE_RUN_CTRL_CYCLE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam int DW = (STAGES > 3) ? $clog2(STAGES - 1) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(STAGES - 2);
  // Widened so the limit compare is exact even when CNT_W is narrower than MAX_CYCLES needs.
  localparam logic [CNT_W+31:0] MAX_EXT = (CNT_W + 32)'(MAX_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              limit_hit_q, limit_hit_d;
  logic              run_q, run_d;
  logic              fetch_en_q, fetch_en_d;
  logic              done_q, done_d;
  logic              limit_now;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    limit_hit_d = limit_hit_q;
    limit_now   = 1'b0;

    if (run_q && (cycle_cnt_q != {CNT_W{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
        end else if (step_req) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (halt_wb) begin
          state_d = S_HALTED;
        end else if (stop_req) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      S_STEP: begin
        state_d = halt_wb ? S_HALTED : S_IDLE;
      end
      S_DRAIN: begin
        if (halt_wb) begin
          state_d = S_HALTED;
        end else if (drain_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    // Watchdog looks at the post-increment count so the halt lands on exactly MAX_CYCLES.
    if (LIMIT_EN && run_q && ({32'd0, cycle_cnt_d} >= MAX_EXT)) begin
      limit_now = 1'b1;
    end
    if (limit_now) begin
      state_d     = S_HALTED;
      limit_hit_d = 1'b1;
    end

    run_d      = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
    fetch_en_d = (state_d == S_RUN) || (state_d == S_STEP);
    done_d     = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      cycle_cnt_q <= '0;
      limit_hit_q <= 1'b0;
      run_q       <= 1'b0;
      fetch_en_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      limit_hit_q <= limit_hit_d;
      run_q       <= run_d;
      fetch_en_q  <= fetch_en_d;
      done_q      <= done_d;
    end
  end

  assign run       = run_q;
  assign fetch_en  = fetch_en_q;
  assign state     = state_q;
  assign cycle_cnt = cycle_cnt_q;
  assign done      = done_q;
  assign limit_hit = limit_hit_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl with a per-cycle behavioural model and literal pins.
// Also builds a 4-bit counter instance to exercise saturation.
module tb_pipeline_run_ctrl;
  localparam int STAGES = 5;
  localparam int MAXC   = 50;
`ifdef PIPELINE_RUN_CTRL_CYCLE_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, step_req = 1'b0, stop_req = 1'b0, halt_wb = 1'b0;
  logic run, fetch_en, done, limit_hit;
  logic [2:0] state;
  logic [31:0] cycle_cnt;
  logic s_run, s_fetch_en, s_done, s_limit_hit;
  logic [2:0] s_state;
  logic [3:0] s_cycle_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // model: mode uses the published state numbering
  int     m_mode = 0;
  int     m_drain_left = 0;
  longint m_cnt = 0;
  bit     m_limit = 1'b0;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(.STAGES(STAGES), .CNT_W(32), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .start(start), .step_req(step_req), .stop_req(stop_req),
    .halt_wb(halt_wb), .run(run), .fetch_en(fetch_en), .state(state),
    .cycle_cnt(cycle_cnt), .done(done), .limit_hit(limit_hit));

  pipeline_run_ctrl #(.STAGES(STAGES), .CNT_W(4), .MAX_CYCLES(MAXC)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .step_req(step_req), .stop_req(stop_req),
    .halt_wb(halt_wb), .run(s_run), .fetch_en(s_fetch_en), .state(s_state),
    .cycle_cnt(s_cycle_cnt), .done(s_done), .limit_hit(s_limit_hit));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit s, input bit st, input bit sp, input bit h, input bit r);
    bit running;
    if (r) begin
      m_mode = 0; m_drain_left = 0; m_cnt = 0; m_limit = 1'b0;
      return;
    end
    running = (m_mode >= 1 && m_mode <= 3);
    if (running && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
    if (m_mode == 0) begin
      if (s) m_mode = 1; else if (st) m_mode = 2;
    end else if (m_mode == 1) begin
      if (h) m_mode = 4;
      else if (sp) begin m_mode = 3; m_drain_left = STAGES - 1; end
    end else if (m_mode == 2) begin
      m_mode = h ? 4 : 0;
    end else if (m_mode == 3) begin
      if (h) m_mode = 4;
      else begin
        m_drain_left--;
        if (m_drain_left == 0) m_mode = 0;
      end
    end
    if (LIM && running && m_cnt >= MAXC) begin
      m_mode = 4; m_limit = 1'b1;
    end
  endtask

  task automatic tick(input bit s, input bit st, input bit sp, input bit h, input bit r);
    start = s; step_req = st; stop_req = sp; halt_wb = h; rst = r;
    @(posedge clk);
    #1;
    model_step(s, st, sp, h, r);
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", state, m_mode);
      check("run", run, (m_mode >= 1 && m_mode <= 3));
      check("fetch_en", fetch_en, (m_mode == 1 || m_mode == 2));
      check("done", done, (m_mode == 4));
      check("limit_hit", limit_hit, m_limit);
      check("cycle_cnt", cycle_cnt, m_cnt);
      check("sat_cnt", s_cycle_cnt, (m_cnt > 15) ? 15 : m_cnt);
    end
  end

  initial begin
    // 1: reset then idle
    tick(0, 0, 0, 0, 1); tick(0, 0, 0, 0, 1);
    idle(3);
    check("t1_state", state, 0); check("t1_run", run, 0);
    check("t1_fetch", fetch_en, 0); check("t1_cnt", cycle_cnt, 0);

    // 2: start, 7 run cycles ending with HALT retired
    tick(1, 0, 0, 0, 0);
    check("t2_run", run, 1);
    idle(6);
    tick(0, 0, 0, 1, 0);
    check("t2_state", state, 4); check("t2_done", done, 1);
    check("t2_run_off", run, 0); check("t2_cnt", cycle_cnt, 7);
    check("t2_model_cnt", m_cnt, 7);
    tick(1, 0, 0, 0, 0); tick(0, 1, 0, 0, 0); tick(0, 0, 1, 1, 0);
    check("t2_sticky", state, 4);

    // 3: 5 RUN cycles, stop, 4 DRAIN cycles; stop held and start in drain ignored
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    idle(4);
    tick(0, 0, 1, 0, 0);
    check("t3_fetch_off", fetch_en, 0); check("t3_drain_run", run, 1);
    tick(0, 0, 1, 0, 0); tick(1, 1, 1, 0, 0); tick(0, 0, 1, 0, 0);
    check("t3_last_drain", run, 1);
    tick(0, 0, 1, 0, 0);
    check("t3_state", state, 0); check("t3_cnt", cycle_cnt, 9);
    check("t3_model_cnt", m_cnt, 9);
    tick(0, 0, 1, 0, 0); tick(0, 0, 1, 0, 0);
    check("t3_no_redrain", state, 0);

    // 4: three single steps
    tick(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0, 0);
      check("t4_step_run", run, 1); check("t4_step_fetch", fetch_en, 1);
      tick(0, 0, 0, 0, 0);
      check("t4_back_idle", state, 0);
      tick(0, 0, 0, 0, 0);
    end
    check("t4_cnt", cycle_cnt, 3);

    // 5: priorities and mid-drain reset
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 0);
    check("t5_halt_idle", state, 0);
    tick(1, 1, 0, 0, 0);
    check("t5_start_wins", state, 1);
    idle(2);
    tick(0, 0, 1, 1, 0);
    check("t5_halt_over_stop", state, 4);
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0); tick(0, 0, 1, 0, 0); tick(0, 0, 0, 0, 0);
    check("t5_in_drain", state, 3);
    tick(0, 0, 0, 0, 1);
    check("t5_rst_state", state, 0); check("t5_rst_run", run, 0);
    check("t5_rst_cnt", cycle_cnt, 0); check("t5_rst_done", done, 0);
    tick(0, 1, 0, 0, 0); tick(1, 1, 1, 1, 0);
    check("t5_step_halt", state, 4);
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0); tick(0, 0, 1, 0, 0); tick(0, 0, 0, 1, 0);
    check("t5_drain_halt", state, 4);

    // 6: long free run, watchdog if built in
    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    idle(60);
    if (LIM) begin
      check("t6_state", state, 4); check("t6_limit", limit_hit, 1);
      check("t6_cnt", cycle_cnt, 50);
    end else begin
      check("t6_state", state, 1); check("t6_limit", limit_hit, 0);
      check("t6_cnt", cycle_cnt, 60);
    end
    check("t6_sat", s_cycle_cnt, 15);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
